scroll_refresh_ctrl: RTL and testbench
======================================

Name: scroll_refresh_ctrl

Overview:
- Upstream producer of refresh_en for the game-state FSM.
- Watches the doodle's vertical position each frame during gameplay. When the doodle climbs above the scroll threshold, it asserts refresh_en and meters out per-frame world-scroll steps.
- The platform and render stages consume the steps; the block also accumulates the height score.
- Also consumes outstate and loadplat from the game-state FSM: pause, main menu and new-game handling.

Parameters:
- THRESH_Y, 160: screen row (0 = top) above which the world scrolls.
- MAX_STEP, 8: maximum pixels scrolled per frame.
- COOL_FRAMES, 1: frame ticks to wait after a scroll before a new trigger is allowed.
- SCORE_W, 16: width of height_score.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- outstate  in  3  game state: 000 menu, 001 game, 010 pause, 011 refreshing.
- loadplat  in  1  one-cycle new-game pulse.
- doodle_y  in  10  doodle top row in pixels, unsigned.
- refresh_en  out  1  high while scroll is pending.
- scroll_valid  out  1  one-cycle pulse: apply scroll_step this frame.
- scroll_step  out  4  pixels to shift world down; valid with scroll_valid.
- height_score  out  SCORE_W  total pixels scrolled since new game, saturating.

Behaviour:
- Interface: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset values: state IDLE, pending=0, cool_cnt=0, refresh_en=0, scroll_valid=0, scroll_step=0, height_score=0.
- Reset mid-scroll returns to IDLE with no further steps.
- Internal registers:
  - pending: 10-bit, saturates at 1023.
  - cool_cnt: counts frame ticks in COOL.
- Game-active definition: outstate==001 or 011. The 011 case covers the one-cycle lag after refresh_en rises.
- IDLE:
  - Condition: frame_tick, outstate==001, doodle_y<THRESH_Y.
  - Action: pending <= THRESH_Y-doodle_y; state SCROLL.
  - Cycle timing: refresh_en=1 in the cycle after the tick. No step is issued on the trigger tick.
- SCROLL (refresh_en=1), on each frame_tick:
  - outstate==010 (pause): ignore tick. No pulse; pending held.
  - Otherwise: step=min(pending,MAX_STEP).
    - Registered: scroll_valid=1, scroll_step=step, in the cycle after the tick.
    - pending <= pending-step+add, where add=(doodle_y<THRESH_Y) ? THRESH_Y-doodle_y : 0, saturating.
    - height_score <= height_score+step, saturating at 2^SCORE_W-1.
  - If the new pending==0: state COOL, cool_cnt=0, refresh_en=0 from the next cycle.
- COOL (refresh_en=0): each frame_tick increments cool_cnt. At COOL_FRAMES, go to IDLE. Ticks in COOL never trigger.
- scroll_valid is high for exactly one cycle per accepted tick. scroll_step holds its last value otherwise.
- outstate==000 (menu), in any state:
  - Next cycle: IDLE, pending=0, refresh_en=0.
  - height_score is kept.
- loadplat=1:
  - Next cycle: IDLE, pending=0, height_score=0, refresh_en=0, scroll_valid=0.
  - Priority: below Reset, above frame_tick (a simultaneous tick is dropped).
- Arithmetic:
  - THRESH_Y-doodle_y is computed only when doodle_y<THRESH_Y; no wrap.
  - MAX_STEP must be ≤15.

Test Plan:
1. Reset held 2 cycles → refresh_en=0, scroll_valid=0, scroll_step=0, height_score=0.
2. outstate=001, doodle_y=140, tick; later ticks with doodle_y=160:
   - refresh_en=1 one cycle after the first tick.
   - Next three ticks give steps 8, 8, 4.
   - height_score=20.
   - refresh_en=0 the cycle after the step-4 pulse.
   - Tick with doodle_y=100 during COOL → no trigger.
   - Next tick → IDLE.
3. outstate=001, doodle_y=200, 5 ticks → refresh_en stays 0, no scroll_valid.
4. Mid-scroll (pending=12), outstate=010 for 3 ticks → no scroll_valid, refresh_en=1. Back to 011 → steps 8, 4.
5. Mid-scroll, loadplat coincident with frame_tick → no scroll_valid; next cycle refresh_en=0, height_score=0.
6. SCORE_W=6, repeated triggers at doodle_y=120 → height_score saturates at 63 and stays there; steps continue.

Source files
------------

// File: rtl/scroll_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scroll_refresh_ctrl
// Brief    : Watches the doodle height each frame, raises refresh_en while a
//            world scroll is owed, meters the scroll out in per-frame steps
//            and accumulates the saturating height score.
// Revision : 1.0 - initial release
// ============================================================================
module scroll_refresh_ctrl #(
    parameter int THRESH_Y    = 160,
    parameter int MAX_STEP    = 8,
    parameter int COOL_FRAMES = 1,
    parameter int SCORE_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [2:0]         outstate,
    input  logic               loadplat,
    input  logic [9:0]         doodle_y,
    output logic               refresh_en,
    output logic               scroll_valid,
    output logic [3:0]         scroll_step,
    output logic [SCORE_W-1:0] height_score
);

    localparam int COOL_W = (COOL_FRAMES > 1) ? $clog2(COOL_FRAMES) : 1;

    localparam logic [COOL_W-1:0]  C_COOL_LAST = COOL_W'(COOL_FRAMES - 1);
    localparam logic [9:0]         C_THRESH    = 10'(THRESH_Y);
    localparam logic [3:0]         C_MAX_STEP  = 4'(MAX_STEP);
    localparam logic [9:0]         C_PEND_MAX  = 10'd1023;
    localparam logic [SCORE_W-1:0] C_SCORE_MAX = '1;

    localparam logic [2:0] C_OS_MENU    = 3'b000;
    localparam logic [2:0] C_OS_GAME    = 3'b001;
    localparam logic [2:0] C_OS_REFRESH = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_COOL   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          pending_q, pending_d;
    logic [COOL_W-1:0]   cool_cnt_q, cool_cnt_d;
    logic                scroll_valid_q, scroll_valid_d;
    logic [3:0]          scroll_step_q, scroll_step_d;
    logic [SCORE_W-1:0]  height_score_q, height_score_d;

    logic                w_below;
    logic [9:0]          w_rise;
    logic [3:0]          w_step;
    logic [10:0]         w_pend_sum;
    logic [9:0]          w_pend_next;
    logic [SCORE_W:0]    w_score_sum;
    logic [SCORE_W-1:0]  w_score_next;
    logic                w_game_active;

    // Datapath: climb distance, metered step and saturating accumulators
    always_comb begin
        w_below       = (doodle_y < C_THRESH);
        // Difference only formed when the doodle is above the line, so no wrap
        w_rise        = w_below ? (C_THRESH - doodle_y) : 10'd0;
        w_step        = (pending_q < {6'd0, C_MAX_STEP}) ? pending_q[3:0] : C_MAX_STEP;
        // pending >= step always, so the 11-bit sum only overflows upward
        w_pend_sum    = {1'b0, pending_q} - {7'd0, w_step} + {1'b0, w_rise};
        w_pend_next   = w_pend_sum[10] ? C_PEND_MAX : w_pend_sum[9:0];
        w_score_sum   = {1'b0, height_score_q} + (SCORE_W+1)'(w_step);
        w_score_next  = w_score_sum[SCORE_W] ? C_SCORE_MAX : w_score_sum[SCORE_W-1:0];
        // 011 is included because the game FSM echoes refresh_en one cycle late
        w_game_active = (outstate == C_OS_GAME) || (outstate == C_OS_REFRESH);
    end

    // Next-state logic: new game beats menu, menu beats any frame tick
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        cool_cnt_d     = cool_cnt_q;
        scroll_valid_d = 1'b0;
        scroll_step_d  = scroll_step_q;
        height_score_d = height_score_q;

        if (loadplat) begin
            state_d        = ST_IDLE;
            pending_d      = 10'd0;
            cool_cnt_d     = '0;
            height_score_d = '0;
        end else if (outstate == C_OS_MENU) begin
            state_d    = ST_IDLE;
            pending_d  = 10'd0;
            cool_cnt_d = '0;
        end else if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if ((outstate == C_OS_GAME) && w_below) begin
                        pending_d = w_rise;
                        state_d   = ST_SCROLL;
                    end
                end
                ST_SCROLL: begin
                    // Pause (and any non-game state) freezes the scroll
                    if (w_game_active) begin
                        scroll_valid_d = 1'b1;
                        scroll_step_d  = w_step;
                        pending_d      = w_pend_next;
                        height_score_d = w_score_next;
                        if (w_pend_next == 10'd0) begin
                            state_d    = ST_COOL;
                            cool_cnt_d = '0;
                        end
                    end
                end
                ST_COOL: begin
                    if (cool_cnt_q == C_COOL_LAST) begin
                        state_d    = ST_IDLE;
                        cool_cnt_d = '0;
                    end else begin
                        cool_cnt_d = cool_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= 10'd0;
            cool_cnt_q     <= '0;
            scroll_valid_q <= 1'b0;
            scroll_step_q  <= 4'd0;
            height_score_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            cool_cnt_q     <= cool_cnt_d;
            scroll_valid_q <= scroll_valid_d;
            scroll_step_q  <= scroll_step_d;
            height_score_q <= height_score_d;
        end
    end

    assign refresh_en   = (state_q == ST_SCROLL);
    assign scroll_valid = scroll_valid_q;
    assign scroll_step  = scroll_step_q;
    assign height_score = height_score_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scroll_refresh_ctrl
// Brief    : Scenario-driven bench; expected scroll pulses are queued when
//            the tick is driven and matched when the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scroll_refresh_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [2:0]  outstate = 3'b000;
    logic        loadplat = 1'b0;
    logic [9:0]  doodle_y = 10'd200;

    logic        refresh_en, scroll_valid;
    logic [3:0]  scroll_step;
    logic [15:0] height_score;

    logic        refresh_en6, scroll_valid6;
    logic [3:0]  scroll_step6;
    logic [5:0]  height_score6;

    int total = 0;
    int bad   = 0;
    bit en6   = 1'b0;

    typedef struct {
        logic [3:0]  step;
        logic [15:0] score;
        logic [5:0]  score6;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 Clock = ~Clock;

    scroll_refresh_ctrl u_dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .outstate     (outstate),
        .loadplat     (loadplat),
        .doodle_y     (doodle_y),
        .refresh_en   (refresh_en),
        .scroll_valid (scroll_valid),
        .scroll_step  (scroll_step),
        .height_score (height_score)
    );

    scroll_refresh_ctrl #(.SCORE_W(6)) u_dut6 (
        .Clock        (Clock),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .outstate     (outstate),
        .loadplat     (loadplat),
        .doodle_y     (doodle_y),
        .refresh_en   (refresh_en6),
        .scroll_valid (scroll_valid6),
        .scroll_step  (scroll_step6),
        .height_score (height_score6)
    );

    // Scoreboard: every scroll pulse must match the oldest queued expectation
    always @(negedge Clock) begin
        if (!Reset && scroll_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse: got step=%0d, required no pulse", scroll_step);
            end else begin
                mon_e = exp_q.pop_front();
                total++;
                if (scroll_step !== mon_e.step) begin
                    bad++;
                    $display("FAIL pulse_step: got %0d, required %0d", scroll_step, mon_e.step);
                end
                total++;
                if (height_score !== mon_e.score) begin
                    bad++;
                    $display("FAIL pulse_score: got %0d, required %0d", height_score, mon_e.score);
                end
                if (en6) begin
                    total++;
                    if (height_score6 !== mon_e.score6) begin
                        bad++;
                        $display("FAIL pulse_score6: got %0d, required %0d", height_score6, mon_e.score6);
                    end
                end
            end
        end
        if (en6) begin
            total++;
            if (scroll_valid6 !== scroll_valid || scroll_step6 !== scroll_step) begin
                bad++;
                $display("FAIL dut6_pulse_align: got valid=%0d step=%0d, required valid=%0d step=%0d",
                         scroll_valid6, scroll_step6, scroll_valid, scroll_step);
            end
        end
    end

    function automatic void push_exp(input logic [3:0] s, input logic [15:0] sc,
                                     input logic [5:0] sc6);
        exp_t e;
        e.step = s; e.score = sc; e.score6 = sc6;
        exp_q.push_back(e);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // One-cycle frame tick; returns just after the edge that sampled it
    task automatic tick(input logic [9:0] y, input logic [2:0] os);
        @(posedge Clock);
        #1;
        doodle_y   = y;
        outstate   = os;
        frame_tick = 1'b1;
        @(posedge Clock);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        wait_cycles(2);
        total++; if (refresh_en !== 1'b0) begin bad++; $display("FAIL reset_refresh_en: got %0d, required 0", refresh_en); end
        total++; if (scroll_valid !== 1'b0) begin bad++; $display("FAIL reset_scroll_valid: got %0d, required 0", scroll_valid); end
        total++; if (scroll_step !== 4'd0) begin bad++; $display("FAIL reset_scroll_step: got %0d, required 0", scroll_step); end
        total++; if (height_score !== 16'd0) begin bad++; $display("FAIL reset_height_score: got %0d, required 0", height_score); end
        Reset = 1'b0;
        outstate = 3'b001;
        wait_cycles(1);
    endtask

    task automatic test_basic_scroll;
        tick(10'd140, 3'b001);
        total++; if (refresh_en !== 1'b1) begin bad++; $display("FAIL trig_refresh_en: got %0d, required 1", refresh_en); end
        total++; if (scroll_valid !== 1'b0) begin bad++; $display("FAIL trig_no_step: got %0d, required 0", scroll_valid); end
        push_exp(4'd8, 16'd8, 6'd0);  tick(10'd160, 3'b001);
        push_exp(4'd8, 16'd16, 6'd0); tick(10'd160, 3'b001);
        push_exp(4'd4, 16'd20, 6'd0); tick(10'd160, 3'b001);
        wait_cycles(1);
        total++; if (refresh_en !== 1'b0) begin bad++; $display("FAIL done_refresh_en: got %0d, required 0", refresh_en); end
        total++; if (height_score !== 16'd20) begin bad++; $display("FAIL basic_score: got %0d, required 20", height_score); end
        // Tick during cool-down must not trigger even with the doodle high
        tick(10'd100, 3'b001);
        wait_cycles(1);
        total++; if (refresh_en !== 1'b0) begin bad++; $display("FAIL cool_no_trigger: got %0d, required 0", refresh_en); end
        // Cool-down has expired, so this tick triggers again
        tick(10'd100, 3'b001);
        total++; if (refresh_en !== 1'b1) begin bad++; $display("FAIL post_cool_trigger: got %0d, required 1", refresh_en); end
        // Menu abandons the scroll but keeps the score
        outstate = 3'b000;
        wait_cycles(1);
        outstate = 3'b001;
        total++; if (refresh_en !== 1'b0) begin bad++; $display("FAIL menu_refresh_en: got %0d, required 0", refresh_en); end
        total++; if (height_score !== 16'd20) begin bad++; $display("FAIL menu_score_kept: got %0d, required 20", height_score); end
    endtask

    task automatic test_no_trigger;
        for (int i = 0; i < 5; i++) begin
            tick(10'd200, 3'b001);
            total++;
            if (refresh_en !== 1'b0) begin
                bad++;
                $display("FAIL low_doodle_%0d: got refresh_en=%0d, required 0", i, refresh_en);
            end
        end
    endtask

    task automatic test_pause;
        tick(10'd148, 3'b001);
        for (int i = 0; i < 3; i++) begin
            tick(10'd160, 3'b010);
            total++;
            if (refresh_en !== 1'b1) begin
                bad++;
                $display("FAIL pause_refresh_en_%0d: got %0d, required 1", i, refresh_en);
            end
        end
        push_exp(4'd8, 16'd28, 6'd0); tick(10'd160, 3'b011);
        push_exp(4'd4, 16'd32, 6'd0); tick(10'd160, 3'b011);
        wait_cycles(1);
        total++; if (refresh_en !== 1'b0) begin bad++; $display("FAIL pause_done_refresh_en: got %0d, required 0", refresh_en); end
        tick(10'd160, 3'b001);
    endtask

    task automatic test_loadplat;
        tick(10'd100, 3'b001);
        push_exp(4'd8, 16'd40, 6'd0); tick(10'd160, 3'b001);
        @(posedge Clock);
        #1;
        loadplat   = 1'b1;
        frame_tick = 1'b1;
        @(posedge Clock);
        #1;
        loadplat   = 1'b0;
        frame_tick = 1'b0;
        total++; if (scroll_valid !== 1'b0) begin bad++; $display("FAIL newgame_no_step: got %0d, required 0", scroll_valid); end
        total++; if (refresh_en !== 1'b0) begin bad++; $display("FAIL newgame_refresh_en: got %0d, required 0", refresh_en); end
        total++; if (height_score !== 16'd0) begin bad++; $display("FAIL newgame_score: got %0d, required 0", height_score); end
        total++; if (height_score6 !== 6'd0) begin bad++; $display("FAIL newgame_score6: got %0d, required 0", height_score6); end
    endtask

    task automatic test_saturate;
        logic [15:0] sc;
        logic [6:0]  sc6;
        sc  = 16'd0;
        sc6 = 7'd0;
        en6 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick(10'd120, 3'b001);
            for (int k = 0; k < 5; k++) begin
                sc  = sc + 16'd8;
                sc6 = (sc6 + 7'd8 > 7'd63) ? 7'd63 : sc6 + 7'd8;
                push_exp(4'd8, sc, sc6[5:0]);
                tick(10'd160, 3'b001);
            end
            tick(10'd160, 3'b001);
        end
        total++; if (height_score6 !== 6'd63) begin bad++; $display("FAIL sat_score6: got %0d, required 63", height_score6); end
        total++; if (height_score !== 16'd80) begin bad++; $display("FAIL sat_score16: got %0d, required 80", height_score); end
        en6 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scroll();
        test_no_trigger();
        test_pause();
        test_loadplat();
        test_saturate();
        wait_cycles(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
